// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port blram between two masters (m0 = CPU, m1 = loader/debug).
// Round-robin between contending masters, with an optional lock that lets the previous
// grantee keep the RAM for up to MAX_BURST consecutive cycles while the other master waits.
// Read data is blram's output passed straight through; rvalid marks the owner one cycle later.
module ram_arbiter #(
    parameter int unsigned ADDR_LEN  = 14,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic                m0_lock,
    input  logic [ADDR_LEN-1:0] m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic                m1_lock,
    input  logic [ADDR_LEN-1:0] m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                ram_we,
    output logic [ADDR_LEN-1:0] ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int unsigned     RunW   = $clog2(MAX_BURST + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(MAX_BURST);
    localparam logic [RunW-1:0] RunOne = RunW'(1);

    // Owner encoding used by last_owner: 0 = m0, 1 = m1.
    logic            last_owner_q, last_owner_d;
    // Set when the previous cycle granted someone; last_owner is then that grantee.
    logic            prev_gnt_q, prev_gnt_d;
    logic [RunW-1:0] run_len_q, run_len_d;
    logic            m0_rvalid_q, m0_rvalid_d;
    logic            m1_rvalid_q, m1_rvalid_d;

    logic            gnt_m0, gnt_m1;
    logic            owner_req, owner_lock;
    logic            lock_hold;
    logic            any_gnt;
    logic            grantee;

    // Decide whether the previous grantee keeps the RAM under its lock.
    always_comb begin
        owner_req  = last_owner_q ? m1_req  : m0_req;
        owner_lock = last_owner_q ? m1_lock : m0_lock;
        lock_hold  = prev_gnt_q && owner_req && owner_lock && (run_len_q < RunMax);
    end

    // Grant selection: lock continuation, then lone requester, then round-robin on a tie.
    always_comb begin
        gnt_m0 = 1'b0;
        gnt_m1 = 1'b0;
        if (rst) begin
            if (lock_hold) begin
                gnt_m0 = ~last_owner_q;
                gnt_m1 = last_owner_q;
            end else if (m0_req && m1_req) begin
                gnt_m0 = last_owner_q;
                gnt_m1 = ~last_owner_q;
            end else begin
                gnt_m0 = m0_req;
                gnt_m1 = m1_req;
            end
        end
    end

    // Route the granted master onto the RAM port; idle and reset drive all zeros.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_m0) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (gnt_m1) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    // Next-state for fairness bookkeeping and read-return flags.
    always_comb begin
        any_gnt      = gnt_m0 | gnt_m1;
        grantee      = gnt_m1;
        last_owner_d = last_owner_q;
        run_len_d    = '0;
        prev_gnt_d   = any_gnt;
        if (any_gnt) begin
            last_owner_d = grantee;
            if (prev_gnt_q && (grantee == last_owner_q)) begin
                run_len_d = (run_len_q == RunMax) ? RunMax : run_len_q + RunOne;
            end else begin
                run_len_d = RunOne;
            end
        end
        m0_rvalid_d = gnt_m0 & ~m0_we;
        m1_rvalid_d = gnt_m1 & ~m1_we;
    end

    // State registers with synchronous active-low reset; m0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner_q <= 1'b1;
            prev_gnt_q   <= 1'b0;
            run_len_q    <= '0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            prev_gnt_q   <= prev_gnt_d;
            run_len_q    <= run_len_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
        end
    end

    // Output assignments; both masters see blram data, qualified by their own rvalid.
    always_comb begin
        m0_gnt    = gnt_m0;
        m1_gnt    = gnt_m1;
        m0_rvalid = m0_rvalid_q;
        m1_rvalid = m1_rvalid_q;
        m0_rdata  = ram_rdata;
        m1_rdata  = ram_rdata;
    end

endmodule
